block_packer: RTL and testbench
===============================

BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, output block width in bits.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, input symbol width in bits.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ss_aresetn_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ss_tvalid_i, input, 1, upstream byte valid.
REQ-006 SHALL have port ss_tdata_i, input, BYTE_WIDTH, upstream byte.
REQ-007 SHALL have port ss_tlast_i, input, 1, final byte of message.
REQ-008 SHALL have port ss_tready_o, output, 1, byte accepted when high with ss_tvalid_i.
REQ-009 SHALL have port sm_aresetn_o, output, 1, reset forwarded to the coder stream slave.
REQ-010 SHALL have port sm_tvalid_o, output, 1, block valid.
REQ-011 SHALL have port sm_tdata_o, output, TDATA_WIDTH, packed 64-bit block for the coder.
REQ-012 SHALL have port sm_tlast_o, output, 1, block carries the message's final byte.
REQ-013 SHALL have port sm_tbytes_o, output, 4, count of valid bytes in block, 1..8.
REQ-014 SHALL have port sm_tready_i, input, 1, downstream (coder) ready.

Function
REQ-015 SHALL pack bytes MSB-first: first accepted byte of a block into [63:56], eighth into [7:0].
REQ-016 SHALL hold an accumulator (data, byte count 0..7, complete flag) and a separate output register (sm_tdata_o/sm_tlast_o/sm_tbytes_o/sm_tvalid_o).
REQ-017 SHALL use accumulator states FILLING (count 0..7, complete=0) and COMPLETE (complete=1).
REQ-018 SHALL go FILLING->COMPLETE on the edge accepting the 8th byte, or any byte with ss_tlast_i=1.
REQ-019 SHALL zero-pad unfilled low bytes of a block closed by ss_tlast_i; sm_tbytes_o = bytes received, sm_tlast_o=1.
REQ-020 SHALL set sm_tlast_o=1 and sm_tbytes_o=8 when tlast arrives on the 8th byte; no extra empty block.
REQ-021 SHALL define out_free = !sm_tvalid_o || sm_tready_i.
REQ-022 SHALL, in COMPLETE with out_free, move the accumulator into the output register at the edge, set sm_tvalid_o=1, and return to FILLING with count 0.
REQ-023 SHALL drive ss_tready_o = !complete || out_free (combinational on sm_tready_i allowed; never on ss_tvalid_i).
REQ-024 SHALL, when a transfer (REQ-022) and a byte acceptance occur on the same edge, load that byte as byte 0 of the new block (count becomes 1, or COMPLETE if it carries tlast).
REQ-025 SHALL clear sm_tvalid_o on an edge with sm_tvalid_o && sm_tready_i and no transfer in.
REQ-026 SHALL hold sm_tdata_o, sm_tlast_o, sm_tbytes_o stable while sm_tvalid_o=1 and sm_tready_i=0.
REQ-027 SHALL have latency: block-closing byte accepted at edge N -> sm_tvalid_o high after edge N+1 if out_free.
REQ-028 SHALL sustain one byte per cycle with sm_tready_i held high (8 bytes per 8 cycles).
REQ-029 SHALL ignore ss_tdata_i/ss_tlast_i when ss_tvalid_i=0.

Reset
REQ-030 SHALL, while ss_aresetn_i=0, asynchronously force count=0, complete=0, accumulator=0, sm_tvalid_o=0, sm_tdata_o=0, sm_tlast_o=0, sm_tbytes_o=0.
REQ-031 SHALL assert sm_aresetn_o=0 asynchronously with ss_aresetn_i and deassert it on the first rising edge after ss_aresetn_i rises (one flop).
REQ-032 SHALL discard any partial block and any pending output block on reset mid-message; no output after reset until new bytes arrive.
REQ-033 SHALL present ss_tready_o=1 from the first edge after reset release.

Structure
REQ-034 SHALL take TDATA_WIDTH, BYTE_WIDTH and BYTES_PER_BLOCK (=TDATA_WIDTH/BYTE_WIDTH) from the shared encryptor package also used by coder.
REQ-035 SHALL be a single module with no sub-modules; the output register is inline, not a generic FIFO.

Verification
REQ-036 SHALL cover: bytes 01,23,45,67,89,ab,cd,ef back-to-back, sm_tready_i=1 -> one block 0123456789abcdef, tbytes=8, tlast=0, valid two edges after byte ef.
REQ-037 SHALL cover: bytes aa,bb,cc with tlast on cc -> block aabbcc0000000000, tbytes=3, tlast=1.
REQ-038 SHALL cover: 16 bytes 00..0f, sm_tready_i=0 -> first block 0001020304050607 held stable; ss_tready_o=0 after 2nd block completes; raising sm_tready_i yields 08090a0b0c0d0e0f next; no byte lost or duplicated.
REQ-039 SHALL cover: 24 bytes continuous, sm_tready_i=1 -> ss_tready_o never drops, three blocks on consecutive 8-cycle spacing.
REQ-040 SHALL cover: reset pulled low after 5 bytes of a block -> all outputs 0 immediately; after release, 8 new bytes 11..88 -> block 1122334455667788 only.
REQ-041 SHALL cover: tlast on 8th byte 10..17 -> single block 1011121314151617, tbytes=8, tlast=1, no following block.

Source files
------------

// File: rtl/block_packer_pkg.sv
// block_packer_pkg
// Shared encryptor constants and types used by the byte packer and the coder.
//   TDATA_WIDTH     : width of one coder block in bits
//   BYTE_WIDTH      : width of one upstream symbol in bits
//   BYTES_PER_BLOCK : symbols per block
//   acc_state_t     : accumulator state (FILLING / COMPLETE)
package block_packer_pkg;

  localparam int TDATA_WIDTH     = 64;
  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_BLOCK = TDATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [0:0] {
    FILLING  = 1'b0,
    COMPLETE = 1'b1
  } acc_state_t;

endpackage

// File: rtl/block_packer.sv
// block_packer
// Packs an upstream byte stream MSB-first into fixed-width blocks for the coder.
// A block closes on its last byte slot or on ss_tlast_i. Short final blocks are
// zero-padded in their low bytes. One accumulator plus one output register lets
// the packer sustain one byte per cycle while the coder is ready.
// Ports:
//   clk_i        : clock, rising-edge active
//   ss_aresetn_i : asynchronous active-low reset
//   ss_tvalid_i / ss_tdata_i / ss_tlast_i / ss_tready_o : upstream byte stream
//   sm_aresetn_o : reset forwarded to the coder, released one edge after ss_aresetn_i
//   sm_tvalid_o / sm_tdata_o / sm_tlast_o / sm_tbytes_o / sm_tready_i : block stream
module block_packer #(
  parameter int TDATA_WIDTH = block_packer_pkg::TDATA_WIDTH,
  parameter int BYTE_WIDTH  = block_packer_pkg::BYTE_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   ss_aresetn_i,
  input  logic                   ss_tvalid_i,
  input  logic [BYTE_WIDTH-1:0]  ss_tdata_i,
  input  logic                   ss_tlast_i,
  output logic                   ss_tready_o,
  output logic                   sm_aresetn_o,
  output logic                   sm_tvalid_o,
  output logic [TDATA_WIDTH-1:0] sm_tdata_o,
  output logic                   sm_tlast_o,
  output logic [3:0]             sm_tbytes_o,
  input  logic                   sm_tready_i
);

  import block_packer_pkg::*;

  localparam int BPB = TDATA_WIDTH / BYTE_WIDTH;

  acc_state_t             state_r;
  acc_state_t             state_nxt_s;
  logic [TDATA_WIDTH-1:0] acc_data_r;
  logic [3:0]             acc_cnt_r;
  logic                   acc_last_r;

  logic                   out_free_s;
  logic                   ss_tready_s;
  logic                   transfer_s;
  logic                   accept_s;
  logic                   closes_s;
  logic [3:0]             base_cnt_s;
  logic [TDATA_WIDTH-1:0] base_data_s;
  logic [TDATA_WIDTH-1:0] slot_data_s;

  // Output register can take a new block when empty or being drained this edge.
  assign out_free_s  = !sm_tvalid_o || sm_tready_i;
  assign accept_s    = ss_tvalid_i && ss_tready_s;
  assign ss_tready_o = ss_tready_s;

  // On a transfer edge the accumulator restarts, so an accepted byte lands in slot 0.
  always_comb begin
    base_cnt_s  = acc_cnt_r;
    base_data_s = acc_data_r;
    if (transfer_s) begin
      base_cnt_s  = 4'd0;
      base_data_s = {TDATA_WIDTH{1'b0}};
    end else begin
      base_cnt_s  = acc_cnt_r;
      base_data_s = acc_data_r;
    end
  end

  // Position the incoming byte MSB-first at the current fill slot.
  assign slot_data_s = {ss_tdata_i, {(TDATA_WIDTH-BYTE_WIDTH){1'b0}}} >> (base_cnt_s * BYTE_WIDTH);
  assign closes_s    = accept_s && (ss_tlast_i || (base_cnt_s == 4'(BPB-1)));

  // Accumulator state register.
  always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      state_r <= FILLING;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a closing byte always lands in COMPLETE, a drain without one returns to FILLING.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILLING: begin
        if (closes_s) begin
          state_nxt_s = COMPLETE;
        end else begin
          state_nxt_s = FILLING;
        end
      end
      COMPLETE: begin
        if (transfer_s && !closes_s) begin
          state_nxt_s = FILLING;
        end else begin
          state_nxt_s = COMPLETE;
        end
      end
      default: state_nxt_s = FILLING;
    endcase
  end

  // State-decoded controls: upstream ready and accumulator-to-output transfer.
  always_comb begin
    ss_tready_s = 1'b0;
    transfer_s  = 1'b0;
    case (state_r)
      FILLING: begin
        ss_tready_s = 1'b1;
        transfer_s  = 1'b0;
      end
      COMPLETE: begin
        ss_tready_s = out_free_s;
        transfer_s  = out_free_s;
      end
      default: begin
        ss_tready_s = 1'b0;
        transfer_s  = 1'b0;
      end
    endcase
  end

  // Accumulator and output register datapath.
  always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      acc_data_r  <= {TDATA_WIDTH{1'b0}};
      acc_cnt_r   <= 4'd0;
      acc_last_r  <= 1'b0;
      sm_tvalid_o <= 1'b0;
      sm_tdata_o  <= {TDATA_WIDTH{1'b0}};
      sm_tlast_o  <= 1'b0;
      sm_tbytes_o <= 4'd0;
    end else begin
      if (transfer_s) begin
        sm_tvalid_o <= 1'b1;
        sm_tdata_o  <= acc_data_r;
        sm_tlast_o  <= acc_last_r;
        sm_tbytes_o <= acc_cnt_r;
      end else if (sm_tvalid_o && sm_tready_i) begin
        sm_tvalid_o <= 1'b0;
      end
      if (accept_s) begin
        acc_data_r <= base_data_s | slot_data_s;
        acc_cnt_r  <= base_cnt_s + 4'd1;
        acc_last_r <= ss_tlast_i;
      end else if (transfer_s) begin
        acc_data_r <= {TDATA_WIDTH{1'b0}};
        acc_cnt_r  <= 4'd0;
        acc_last_r <= 1'b0;
      end
    end
  end

  // Coder reset: asserted with ours, released one edge after ours rises.
  always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      sm_aresetn_o <= 1'b0;
    end else begin
      sm_aresetn_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_block_packer.sv
module tb_block_packer;

  logic        clk;
  logic        rst_n;
  logic        ss_tvalid_i;
  logic [7:0]  ss_tdata_i;
  logic        ss_tlast_i;
  logic        ss_tready_o;
  logic        sm_aresetn_o;
  logic        sm_tvalid_o;
  logic [63:0] sm_tdata_o;
  logic        sm_tlast_o;
  logic [3:0]  sm_tbytes_o;
  logic        sm_tready_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;

  // Reference model: bytes of the block being built and the blocks still owed.
  logic [7:0]  cur[$];
  logic [63:0] exp_data[$];
  logic [3:0]  exp_bytes[$];
  logic        exp_last[$];
  int          out_cyc[$];

  block_packer dut (
    .clk_i        (clk),
    .ss_aresetn_i (rst_n),
    .ss_tvalid_i  (ss_tvalid_i),
    .ss_tdata_i   (ss_tdata_i),
    .ss_tlast_i   (ss_tlast_i),
    .ss_tready_o  (ss_tready_o),
    .sm_aresetn_o (sm_aresetn_o),
    .sm_tvalid_o  (sm_tvalid_o),
    .sm_tdata_o   (sm_tdata_o),
    .sm_tlast_o   (sm_tlast_o),
    .sm_tbytes_o  (sm_tbytes_o),
    .sm_tready_i  (sm_tready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 64'(sm_tvalid_o), 64'd0);
    check({name, "_data"},  sm_tdata_o,        64'd0);
    check({name, "_last"},  64'(sm_tlast_o),  64'd0);
    check({name, "_bytes"}, 64'(sm_tbytes_o), 64'd0);
  endtask

  // Offer one byte and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] b, input logic last);
    int waitc;
    waitc = 0;
    ss_tvalid_i = 1'b1;
    ss_tdata_i  = b;
    ss_tlast_i  = last;
    @(negedge clk);
    while (!ss_tready_o && waitc < 200) begin
      waitc++;
      stall_cnt++;
      @(negedge clk);
    end
    if (waitc >= 200) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    ss_tvalid_i = 1'b0;
    ss_tlast_i  = 1'b0;
  endtask

  // Model and compare process: observes handshakes mid-cycle.
  initial begin
    logic        hold_v;
    logic [63:0] hold_d;
    logic        hold_l;
    logic [3:0]  hold_b;
    logic [63:0] d;
    logic [63:0] ed;
    logic [3:0]  eb;
    logic        el;
    hold_v = 1'b0;
    hold_d = 64'd0;
    hold_l = 1'b0;
    hold_b = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur.delete();
        exp_data.delete();
        exp_bytes.delete();
        exp_last.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 64'(sm_tvalid_o), 64'd1);
          check("hold_data",  sm_tdata_o,       hold_d);
          check("hold_last",  64'(sm_tlast_o), 64'(hold_l));
          check("hold_bytes", 64'(sm_tbytes_o), 64'(hold_b));
        end
        if (sm_tvalid_o && sm_tready_i) begin
          out_cyc.push_back(cyc);
          if (exp_data.size() == 0) begin
            check("extra_block", sm_tdata_o, 64'hxxxxxxxxxxxxxxxx);
          end else begin
            ed = exp_data.pop_front();
            eb = exp_bytes.pop_front();
            el = exp_last.pop_front();
            check("blk_data",  sm_tdata_o,        ed);
            check("blk_bytes", 64'(sm_tbytes_o), 64'(eb));
            check("blk_last",  64'(sm_tlast_o),  64'(el));
          end
        end
        hold_v = sm_tvalid_o && !sm_tready_i;
        hold_d = sm_tdata_o;
        hold_l = sm_tlast_o;
        hold_b = sm_tbytes_o;
        if (ss_tvalid_i && ss_tready_o) begin
          cur.push_back(ss_tdata_i);
          if (cur.size() == 8 || ss_tlast_i) begin
            d = 64'd0;
            for (int k = 0; k < cur.size(); k++) d[63-8*k -: 8] = cur[k];
            exp_data.push_back(d);
            exp_bytes.push_back(4'(cur.size()));
            exp_last.push_back(ss_tlast_i);
            cur.delete();
          end
        end
      end
    end
  end

  initial begin
    int n0;
    rst_n       = 1'b0;
    ss_tvalid_i = 1'b0;
    ss_tdata_i  = 8'h00;
    ss_tlast_i  = 1'b0;
    sm_tready_i = 1'b1;
    #1;
    check_zero("rst");
    check("rst_sm_aresetn", 64'(sm_aresetn_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rel_sm_aresetn_pre", 64'(sm_aresetn_o), 64'd0);
    @(posedge clk);
    #1;
    check("rel_sm_aresetn_post", 64'(sm_aresetn_o), 64'd1);
    check("rel_tready", 64'(ss_tready_o), 64'd1);

    // Eight bytes back-to-back, coder always ready.
    send(8'h01, 1'b0); send(8'h23, 1'b0); send(8'h45, 1'b0); send(8'h67, 1'b0);
    send(8'h89, 1'b0); send(8'hab, 1'b0); send(8'hcd, 1'b0); send(8'hef, 1'b0);
    check("lat_not_yet", 64'(sm_tvalid_o), 64'd0);
    @(posedge clk); #1;
    check("b8_valid", 64'(sm_tvalid_o), 64'd1);
    check("b8_data",  sm_tdata_o,        64'h0123456789abcdef);
    check("b8_bytes", 64'(sm_tbytes_o), 64'd8);
    check("b8_last",  64'(sm_tlast_o),  64'd0);
    @(posedge clk); #1;
    check("b8_drained", 64'(sm_tvalid_o), 64'd0);

    // Data and tlast are ignored while tvalid is low.
    ss_tdata_i = 8'h5a;
    ss_tlast_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_block", 64'(sm_tvalid_o), 64'd0);
    ss_tlast_i = 1'b0;

    // Short block closed by tlast.
    send(8'haa, 1'b0); send(8'hbb, 1'b0); send(8'hcc, 1'b1);
    @(posedge clk); #1;
    check("b3_data",  sm_tdata_o,        64'haabbcc0000000000);
    check("b3_bytes", 64'(sm_tbytes_o), 64'd3);
    check("b3_last",  64'(sm_tlast_o),  64'd1);
    @(posedge clk); #1;

    // Backpressure: coder stalled across two full blocks.
    sm_tready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    check("bp_tready_low", 64'(ss_tready_o), 64'd0);
    check("bp_first_data", sm_tdata_o,      64'h0001020304050607);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_held", sm_tdata_o, 64'h0001020304050607);
    sm_tready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_second_valid", 64'(sm_tvalid_o), 64'd1);
    check("bp_second_data",  sm_tdata_o,       64'h08090a0b0c0d0e0f);
    @(posedge clk); #1;
    check("bp_drained", 64'(sm_tvalid_o), 64'd0);

    // 24 continuous bytes: no stall, blocks 8 cycles apart.
    n0 = out_cyc.size();
    stall_cnt = 0;
    for (int i = 0; i < 24; i++) send(8'(8'h40 + i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("thr_stalls", 64'(stall_cnt), 64'd0);
    check("thr_blocks", 64'(out_cyc.size() - n0), 64'd3);
    if (out_cyc.size() >= n0 + 3) begin
      check("thr_gap1", 64'(out_cyc[n0+1] - out_cyc[n0]),   64'd8);
      check("thr_gap2", 64'(out_cyc[n0+2] - out_cyc[n0+1]), 64'd8);
    end

    // Reset in the middle of a block discards it.
    send(8'ha0, 1'b0); send(8'ha1, 1'b0); send(8'ha2, 1'b0); send(8'ha3, 1'b0); send(8'ha4, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    check("mid_rst_sm_aresetn", 64'(sm_aresetn_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_tready", 64'(ss_tready_o), 64'd1);
    check("mid_rel_no_out", 64'(sm_tvalid_o), 64'd0);
    for (int i = 1; i <= 8; i++) send(8'(8'h11 * i), 1'b0);
    @(posedge clk); #1;
    check("post_rst_data", sm_tdata_o, 64'h1122334455667788);
    @(posedge clk); #1;

    // tlast on the eighth byte: one full final block, nothing after.
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), (i == 7) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    check("l8_data",  sm_tdata_o,        64'h1011121314151617);
    check("l8_bytes", 64'(sm_tbytes_o), 64'd8);
    check("l8_last",  64'(sm_tlast_o),  64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("l8_no_follow", 64'(sm_tvalid_o), 64'd0);
    end

    check("model_drained", 64'(exp_data.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
